// File: rtl/stdp_weight_update.sv
// Online STDP learning stage: per-synapse pre traces plus one post trace drive
// saturating weight increments (LTP) and decrements (LTD), with a host write port.
module stdp_weight_update #(
    parameter int N_SYN     = 3,
    parameter int W_WIDTH   = 3,
    parameter int W_INIT    = 2,
    parameter int W_MAX     = 7,
    parameter int W_MIN     = 0,
    parameter int TRACE_LEN = 4,
    parameter int TR_WIDTH  = 3,
    localparam int A_WIDTH  = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     learn_en,
    input  logic [N_SYN-1:0]         pre_spike,
    input  logic                     post_spike,
    input  logic                     wr_en,
    input  logic [A_WIDTH-1:0]       wr_addr,
    input  logic [W_WIDTH-1:0]       wr_data,
    output logic [N_SYN*W_WIDTH-1:0] weights,
    output logic [N_SYN-1:0]         w_changed
);
    localparam logic [TR_WIDTH-1:0] TRACE_START = TR_WIDTH'(TRACE_LEN);
    localparam logic [TR_WIDTH-1:0] TR_ONE      = TR_WIDTH'(1);
    localparam logic [W_WIDTH-1:0]  W_INIT_W    = W_WIDTH'(W_INIT);
    localparam logic [W_WIDTH:0]    W_MAX_X     = (W_WIDTH + 1)'(W_MAX);
    localparam logic [W_WIDTH:0]    W_MIN_X     = (W_WIDTH + 1)'(W_MIN);
    localparam logic [W_WIDTH:0]    W_ONE_X     = (W_WIDTH + 1)'(1);

    logic [TR_WIDTH-1:0] post_trace_q;
    logic [TR_WIDTH-1:0] post_trace_d;
    logic                post_active;

    always_comb begin
        post_trace_d = post_trace_q;
        if (post_spike) begin
            post_trace_d = TRACE_START;
        end else if (post_trace_q != '0) begin
            post_trace_d = post_trace_q - TR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_trace_q <= '0;
        end else begin
            post_trace_q <= post_trace_d;
        end
    end

    // Rules use the pre-edge trace, so a spike never pairs with itself.
    assign post_active = (post_trace_q != '0);

    genvar gi;
    generate
        for (gi = 0; gi < N_SYN; gi++) begin : g_syn
            logic [TR_WIDTH-1:0] pre_trace_q;
            logic [TR_WIDTH-1:0] pre_trace_d;
            logic [W_WIDTH-1:0]  weight_q;
            logic [W_WIDTH-1:0]  weight_d;
            logic [W_WIDTH:0]    w_ext;
            logic [W_WIDTH:0]    w_stdp;
            logic                changed_q;
            logic                ltp;
            logic                ltd;
            logic                wr_hit;

            assign ltp    = learn_en & post_spike & (pre_trace_q != '0);
            assign ltd    = learn_en & pre_spike[gi] & post_active;
            assign wr_hit = wr_en & (wr_addr == A_WIDTH'(gi));
            assign w_ext  = {1'b0, weight_q};

            always_comb begin
                pre_trace_d = pre_trace_q;
                if (pre_spike[gi]) begin
                    pre_trace_d = TRACE_START;
                end else if (pre_trace_q != '0) begin
                    pre_trace_d = pre_trace_q - TR_ONE;
                end
            end

            // Widened arithmetic keeps saturation exact even for host-written values outside [W_MIN, W_MAX].
            always_comb begin
                w_stdp = w_ext;
                if (ltp && !ltd) begin
                    w_stdp = (w_ext >= W_MAX_X) ? W_MAX_X : (w_ext + W_ONE_X);
                end else if (ltd && !ltp) begin
                    w_stdp = (w_ext <= W_MIN_X) ? W_MIN_X : (w_ext - W_ONE_X);
                end
            end

            assign weight_d = wr_hit ? wr_data : w_stdp[W_WIDTH-1:0];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_trace_q <= '0;
                    weight_q    <= W_INIT_W;
                    changed_q   <= 1'b0;
                end else begin
                    pre_trace_q <= pre_trace_d;
                    weight_q    <= weight_d;
                    changed_q   <= (weight_d != weight_q);
                end
            end

            assign weights[gi*W_WIDTH +: W_WIDTH] = weight_q;
            assign w_changed[gi]                  = changed_q;
        end
    endgenerate

endmodule

// File: tb/tb_stdp_weight_update.sv
// Scoreboard bench for stdp_weight_update: each driven cycle queues the expected
// {weights, w_changed} after its edge; a monitor pops and compares after every edge.
module tb_stdp_weight_update;
    logic       clk;
    logic       rst;
    logic       learn_en;
    logic [2:0] pre_spike;
    logic       post_spike;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [2:0] wr_data;
    logic [8:0] weights;
    logic [2:0] w_changed;

    typedef struct {
        int         edge_no;
        string      tag;
        logic [11:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    stdp_weight_update dut (
        .clk        (clk),
        .rst        (rst),
        .learn_en   (learn_en),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .weights    (weights),
        .w_changed  (w_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=0x%0h", tag, got);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                e = sb_q.pop_front();
                chk(e.tag, {20'd0, weights, w_changed}, {20'd0, e.val});
            end
        end
    end

    // Drive one cycle of stimulus and queue the result expected after its edge.
    task automatic cyc(input string tag, input logic [2:0] pre, input logic post,
                       input logic learn, input logic rst_v, input logic wen,
                       input logic [1:0] waddr, input logic [2:0] wdata,
                       input logic [2:0] ew2, input logic [2:0] ew1,
                       input logic [2:0] ew0, input logic [2:0] ec);
        exp_t e;
        rst        = rst_v;
        learn_en   = learn;
        pre_spike  = pre;
        post_spike = post;
        wr_en      = wen;
        wr_addr    = waddr;
        wr_data    = wdata;
        e.edge_no  = edge_cnt + 1;
        e.tag      = tag;
        e.val      = {ew2, ew1, ew0, ec};
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n, input logic learn,
                        input logic [2:0] w2, input logic [2:0] w1, input logic [2:0] w0);
        for (int i = 0; i < n; i++) begin
            cyc(tag, 3'b000, 1'b0, learn, 1'b0, 1'b0, 2'd0, 3'd0, w2, w1, w0, 3'b000);
        end
    endtask

    initial begin
        // reset
        cyc("reset0", 3'b000, 0, 0, 1, 0, 2'd0, 3'd0, 2, 2, 2, 3'b000);
        cyc("reset1", 3'b000, 0, 0, 1, 1, 2'd0, 3'd7, 2, 2, 2, 3'b000);

        // LTP at age 2, 4 and 5 (outside window)
        cyc("ltp2_pre",  3'b001, 0, 1, 0, 0, 2'd0, 3'd0, 2, 2, 2, 3'b000);
        cyc("ltp2_gap",  3'b000, 0, 1, 0, 0, 2'd0, 3'd0, 2, 2, 2, 3'b000);
        cyc("ltp2_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 2, 3, 3'b001);
        idle("ltp2_idle", 5, 1, 2, 2, 3);
        cyc("ltp4_pre",  3'b001, 0, 1, 0, 0, 2'd0, 3'd0, 2, 2, 3, 3'b000);
        idle("ltp4_gap", 3, 1, 2, 2, 3);
        cyc("ltp4_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 2, 4, 3'b001);
        idle("ltp4_idle", 5, 1, 2, 2, 4);
        cyc("ltp5_pre",  3'b001, 0, 1, 0, 0, 2'd0, 3'd0, 2, 2, 4, 3'b000);
        idle("ltp5_gap", 4, 1, 2, 2, 4);
        cyc("ltp5_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 2, 4, 3'b000);
        idle("ltp5_idle", 5, 1, 2, 2, 4);

        // LTD down to the floor
        cyc("ltd1_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 2, 4, 3'b000);
        cyc("ltd1_pre",  3'b010, 0, 1, 0, 0, 2'd0, 3'd0, 2, 1, 4, 3'b010);
        idle("ltd1_idle", 5, 1, 2, 1, 4);
        cyc("ltd2_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 1, 4, 3'b000);
        cyc("ltd2_pre",  3'b010, 0, 1, 0, 0, 2'd0, 3'd0, 2, 0, 4, 3'b010);
        idle("ltd2_idle", 5, 1, 2, 0, 4);
        cyc("ltd3_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 0, 4, 3'b000);
        cyc("ltd3_floor", 3'b010, 0, 1, 0, 0, 2'd0, 3'd0, 2, 0, 4, 3'b000);
        idle("ltd3_idle", 5, 1, 2, 0, 4);

        // LTP at the ceiling
        cyc("sat_wr",   3'b000, 0, 1, 0, 1, 2'd0, 3'd7, 2, 0, 7, 3'b001);
        cyc("sat_pre",  3'b001, 0, 1, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        cyc("sat_post", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        idle("sat_idle", 5, 1, 2, 0, 7);

        // coincidence with cold traces, then LTP/LTD cancel on synapse 2
        cyc("coinc",    3'b111, 1, 1, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        idle("coinc_idle", 5, 1, 2, 0, 7);
        cyc("cx_pre",   3'b100, 0, 0, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        cyc("cx_post",  3'b000, 1, 0, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        cyc("cx_gap",   3'b000, 0, 0, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        cyc("cancel",   3'b100, 1, 1, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        idle("cx_idle", 5, 1, 2, 0, 7);

        // write priority, out-of-range address, same-value write
        cyc("wp_pre",   3'b011, 0, 1, 0, 0, 2'd0, 3'd0, 2, 0, 7, 3'b000);
        cyc("wp_post",  3'b000, 1, 1, 0, 1, 2'd0, 3'd5, 2, 1, 5, 3'b011);
        idle("wp_idle", 5, 1, 2, 1, 5);
        cyc("wr_addr3", 3'b000, 0, 1, 0, 1, 2'd3, 3'd6, 2, 1, 5, 3'b000);
        cyc("wr_same",  3'b000, 0, 1, 0, 1, 2'd2, 3'd2, 2, 1, 5, 3'b000);

        // learn_en=0 keeps traces running; reset mid-window clears them
        cyc("nl_pre",   3'b001, 0, 0, 0, 0, 2'd0, 3'd0, 2, 1, 5, 3'b000);
        cyc("nl_post",  3'b000, 1, 0, 0, 0, 2'd0, 3'd0, 2, 1, 5, 3'b000);
        cyc("nl_ltp",   3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 1, 6, 3'b001);
        cyc("mid_rst",  3'b000, 1, 1, 1, 1, 2'd0, 3'd7, 2, 2, 2, 3'b000);
        cyc("post_rst", 3'b000, 1, 1, 0, 0, 2'd0, 3'd0, 2, 2, 2, 3'b000);
        idle("drain", 2, 1, 2, 2, 2);

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stdp_weight_update.md
Name: stdp_weight_update

Overview:
- Online STDP learning stage that produces the synaptic weights (w1i..w3i) consumed by the LIF neuron.
- Observes the neuron's presynaptic input spikes and its postsynaptic output spike.
- Potentiates a synapse whose input fired shortly before an output spike; depresses a synapse whose input fires shortly after one.
- Holds the weight registers, with a host write port for initialisation and override.

Parameters:
- N_SYN, 3, number of synapses (one per neuron input).
- W_WIDTH, 3, bits per weight (unsigned).
- W_INIT, 2, weight value loaded into every synapse on reset.
- W_MAX, 7, potentiation saturation ceiling; must not exceed 2^W_WIDTH-1.
- W_MIN, 0, depression saturation floor; must satisfy W_MIN <= W_INIT <= W_MAX.
- TRACE_LEN, 4, STDP window length in cycles; range 1..2^TR_WIDTH-1.
- TR_WIDTH, 3, trace counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- learn_en  in  1  1 = STDP updates enabled; traces run regardless.
- pre_spike  in  N_SYN  presynaptic spikes; bit i = neuron_in(i+1).
- post_spike  in  1  neuron_out from the LIF neuron.
- wr_en  in  1  host weight write strobe.
- wr_addr  in  clog2(N_SYN) (min 1)  synapse index for the write.
- wr_data  in  W_WIDTH  weight value to write.
- weights  out  N_SYN*W_WIDTH  packed registered weights; synapse i at [i*W_WIDTH +: W_WIDTH].
- w_changed  out  N_SYN  1-cycle pulse per synapse whose weight changed on the last edge.

Behaviour:
- Reset (rst=1 at an edge):
  - every weight <= W_INIT;
  - all pre_trace[i] and post_trace <= 0;
  - w_changed <= 0.
  - Reset overrides all other activity, including mid-window traces and a concurrent wr_en.
- Pre traces (per synapse, independent of learn_en):
  - pre_spike[i]=1 at an edge: pre_trace[i] <= TRACE_LEN.
  - Otherwise: decrement by 1, saturating at 0.
- Post trace: same rule, driven by post_spike.
- Trace values in the update rules below are the pre-edge registered values. A spike therefore never pairs with itself, and a coincident pre/post pair in the same cycle causes no STDP change from that pairing.
- Potentiation (LTP):
  - Fires at an edge where learn_en=1, post_spike=1 and pre_trace[i]!=0.
  - Condition means synapse i spiked 1..TRACE_LEN cycles earlier.
  - Action: weight[i] <= min(weight[i]+1, W_MAX).
- Depression (LTD):
  - Fires at an edge where learn_en=1, pre_spike[i]=1 and post_trace!=0.
  - Action: weight[i] <= max(weight[i]-1, W_MIN).
- LTP and LTD on the same synapse in the same cycle cancel: weight unchanged.
- Arithmetic: use W_WIDTH+1-bit intermediates so saturation is exact and the weight never wraps (7+1 stays 7; 0-1 stays 0).
- Host write: wr_en=1 sets weight[wr_addr] <= wr_data, overriding any STDP update to that synapse in that cycle.
  - Other synapses still learn normally.
  - wr_addr >= N_SYN: write ignored.
  - wr_data is stored unclamped; the host is responsible for the value.
- w_changed[i] is registered: 1 in the cycle after an edge on which weight[i] took a new value (from STDP or a write); 0 if the written value equals the old one.
- Latency: the weights output reflects an update one edge after the triggering spike.
- Integration note: the LIF neuron's output is registered one cycle behind its inputs. A pre spike that causes a post spike is therefore seen with trace age >= 1, which falls inside the window.
- No FSM state beyond the traces; all behaviour is fully synchronous.

Test Plan:
- Reset: assert rst for 2 cycles -> weights = {2,2,2} (packed 9'b010_010_010), w_changed=0, all traces 0.
- LTP, boundary: learn_en=1; pre_spike=3'b001 at cycle 0, post_spike at cycle 2 -> weight[0]=3, w_changed=3'b001 at cycle 3, others unchanged. Repeat with post 4 cycles after pre -> +1. Repeat with post 5 cycles after pre -> no change.
- LTD and saturation:
  - post at cycle 0, pre_spike=3'b010 at cycle 1 -> weight[1]=1; repeat -> 0; repeat -> stays 0 with no w_changed pulse.
  - Same pattern, mirrored for LTP, with weight preset to 7 -> stays 7.
- Coincidence and cancel:
  - pre and post in the same cycle with all traces 0 -> no change.
  - synapse 2 has pre_trace=2 and post_trace=3, then pre_spike[2] and post_spike coincide -> LTP and LTD cancel, weight[2] unchanged.
- Write priority: wr_en=1, wr_addr=0, wr_data=5 on the same edge as an LTP event on synapses 0 and 1 -> weight[0]=5, weight[1] incremented; wr_addr=3 -> ignored.
- learn_en=0 and mid-window reset:
  - learn_en=0 with pre at cycle 0, post at cycle 1 -> weights unchanged.
  - Then learn_en=1 and a post at cycle 2 -> LTP applies, because traces kept running.
  - rst at cycle 3 followed by a post -> no LTP; weights = W_INIT.
